// File: rtl/vsm.sv
`default_nettype none
// ============================================================================
// Module      : vsm
// Description : Vector-scalar multiply-accumulate lane array. Each enabled
//               cycle, SIZE unsigned 8-bit lanes are multiplied by a shared
//               8-bit scalar and the low byte of each product is added
//               (mod 256) into that lane's accumulator. Three-stage pipeline
//               (input, product, accumulator), all stages gated by enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vsm #(
    parameter int SIZE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [8*SIZE-1:0]   a,
    input  logic [7:0]          b,
    output logic [8*SIZE-1:0]   out
);

    // Stage 1 operand registers
    logic [8*SIZE-1:0] a_q;
    logic [7:0]        b_q;

    // Stage 1: capture the vector and scalar operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (enable) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Per-lane stages 2 and 3; lanes never interact
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [7:0] prod_low;
        logic [7:0] prod;
        logic [7:0] acc;

        // Only the low byte of the 16-bit product is ever kept, so the
        // multiply is evaluated in an 8-bit context (identical low byte).
        assign prod_low = a_q[8*i +: 8] * b_q;

        // Stage 2 product register and stage 3 wrap-around accumulator
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prod <= '0;
                acc  <= '0;
            end else if (enable) begin
                prod <= prod_low;
                acc  <= acc + prod;
            end
        end

        assign out[8*i +: 8] = acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_vsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_vsm
// Description : Self-checking bench for vsm: directed scenarios plus random
//               stimulus against a per-lane arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vsm;

    localparam int SIZE = 3;
    localparam int W    = 8 * SIZE;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [W-1:0] a;
    logic [7:0]   b;
    logic [W-1:0] out;

    int pass_cnt;
    int total_cnt;

    // Reference model: accumulated lane sums plus the list of sampled
    // operand pairs still travelling towards the accumulator.
    int          m_acc [SIZE];
    logic [W-1:0] q_a [$];
    logic [7:0]   q_b [$];

    vsm #(.SIZE(SIZE)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .a      (a),
        .b      (b),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model reset: nothing accumulated, two empty (zero) slots in flight
    function automatic void model_clear();
        for (int i = 0; i < SIZE; i++) m_acc[i] = 0;
        q_a.delete();
        q_b.delete();
        q_a.push_back('0); q_b.push_back('0);
        q_a.push_back('0); q_b.push_back('0);
    endfunction

    // A sample is added two enabled edges after the edge that took it
    function automatic void model_edge(input logic [W-1:0] va, input logic [7:0] vb);
        logic [W-1:0] oa;
        logic [7:0]   ob;
        q_a.push_back(va);
        q_b.push_back(vb);
        oa = q_a.pop_front();
        ob = q_b.pop_front();
        for (int i = 0; i < SIZE; i++)
            m_acc[i] = (m_acc[i] + ((int'(oa[8*i +: 8]) * int'(ob)) % 256)) % 256;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [W-1:0] r;
        for (int i = 0; i < SIZE; i++) r[8*i +: 8] = 8'(m_acc[i]);
        return r;
    endfunction

    // Drive one cycle of inputs, clock it, and let the model follow
    task automatic step(input logic en, input logic [W-1:0] va, input logic [7:0] vb);
        @(negedge clk);
        enable = en;
        a      = va;
        b      = vb;
        @(posedge clk);
        if (en && reset) model_edge(va, vb);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        a      = '0;
        b      = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        total_cnt++;
        if (out !== 24'h000000)
            $display("FAIL reset_state: out=%06h expected=000000", out);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_tab [5];
        logic [W-1:0] va_tab  [5];
        logic [7:0]   vb_tab  [5];
        exp_tab = '{24'h000000, 24'h000000, 24'h010407, 24'h050E17, 24'h0E2032};
        va_tab  = '{24'h010407, 24'h020508, 24'h030609, 24'h000000, 24'h000000};
        vb_tab  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, va_tab[k], vb_tab[k]);
            total_cnt++;
            if (out !== exp_tab[k] || out !== model_out())
                $display("FAIL basic_edge%0d: out=%06h expected=%06h", k + 1, out, exp_tab[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] exp_tab [6];
        logic [W-1:0] va_tab  [5];
        logic [7:0]   vb_tab  [5];
        int           n_en;
        exp_tab = '{24'h000000, 24'h000000, 24'h000000, 24'h010407, 24'h050E17, 24'h0E2032};
        va_tab  = '{24'h010407, 24'h020508, 24'h030609, 24'h000000, 24'h000000};
        vb_tab  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        pulse_reset();
        n_en = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, va_tab[k], vb_tab[k]);
            n_en++;
            total_cnt++;
            if (out !== exp_tab[n_en])
                $display("FAIL gaps_edge%0d: out=%06h expected=%06h", n_en, out, exp_tab[n_en]);
            else pass_cnt++;
            if (k < 3) begin
                step(1'b0, 24'hA5A5A5, 8'h5A);
                total_cnt++;
                if (out !== exp_tab[n_en])
                    $display("FAIL gaps_hold%0d: out=%06h expected=%06h", n_en, out, exp_tab[n_en]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_tab [5];
        exp_tab = '{24'h000000, 24'h000000, 24'h010101, 24'h020202, 24'h020202};
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 2) step(1'b1, 24'hFFFFFF, 8'hFF);
            else       step(1'b1, 24'h000000, 8'h00);
            total_cnt++;
            if (out !== exp_tab[k])
                $display("FAIL wrap_edge%0d: out=%06h expected=%06h", k + 1, out, exp_tab[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        test_basic();
        // Fresh data in flight so the reset also has something to discard
        step(1'b1, 24'h111111, 8'h11);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        total_cnt++;
        if (out !== 24'h000000)
            $display("FAIL async_reset_immediate: out=%06h expected=000000", out);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 24'h000000, 8'h00);
            total_cnt++;
            if (out !== 24'h000000)
                $display("FAIL async_reset_held%0d: out=%06h expected=000000", k, out);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 24'h000000, 8'h00);
            total_cnt++;
            if (out !== 24'h000000)
                $display("FAIL async_reset_flushed%0d: out=%06h expected=000000", k, out);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        test_basic();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 24'hFFFFFF, 8'hFF);
            total_cnt++;
            if (out !== 24'h0E2032)
                $display("FAIL hold_cycle%0d: out=%06h expected=0E2032", k, out);
            else pass_cnt++;
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 24'h000000, 8'h00);
            total_cnt++;
            if (out !== 24'h0E2032)
                $display("FAIL hold_flush%0d: out=%06h expected=0E2032", k, out);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic         en;
        logic [W-1:0] va;
        logic [7:0]   vb;
        pulse_reset();
        for (int k = 0; k < 300; k++) begin
            en = ($urandom_range(0, 9) < 7);
            va = W'($urandom);
            vb = 8'($urandom);
            step(en, va, vb);
            total_cnt++;
            if (out !== model_out())
                $display("FAIL random_cycle%0d: out=%06h expected=%06h", k, out, model_out());
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        a         = '0;
        b         = '0;
        model_clear();
        test_reset();
        test_basic();
        test_gaps();
        test_wrap();
        test_async_reset();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
